// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Brief    : Scan-code constants and FSM encoding for the PS/2 key decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POP    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DECODE = 2'd3
    } ps2_state_t;

endpackage

`default_nettype wire

// File: rtl/ps2_scan_to_ascii.sv
// ============================================================================
// Module   : ps2_scan_to_ascii
// Brief    : Combinational set-2 scan code to ASCII lookup (letters, digits,
//            space, enter); extended and unlisted codes map to 0x00.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_scan_to_ascii (
    input  logic [7:0] code_i,
    input  logic       ext_i,
    input  logic       upper_i,
    output logic [7:0] ascii_o
);

    logic [7:0] letter;
    logic [7:0] other;

    always_comb begin
        letter = 8'h00;
        other  = 8'h00;
        case (code_i)
            8'h1C: letter = "a";
            8'h32: letter = "b";
            8'h21: letter = "c";
            8'h23: letter = "d";
            8'h24: letter = "e";
            8'h2B: letter = "f";
            8'h34: letter = "g";
            8'h33: letter = "h";
            8'h43: letter = "i";
            8'h3B: letter = "j";
            8'h42: letter = "k";
            8'h4B: letter = "l";
            8'h3A: letter = "m";
            8'h31: letter = "n";
            8'h44: letter = "o";
            8'h4D: letter = "p";
            8'h15: letter = "q";
            8'h2D: letter = "r";
            8'h1B: letter = "s";
            8'h2C: letter = "t";
            8'h3C: letter = "u";
            8'h2A: letter = "v";
            8'h1D: letter = "w";
            8'h22: letter = "x";
            8'h35: letter = "y";
            8'h1A: letter = "z";
            8'h45: other  = "0";
            8'h16: other  = "1";
            8'h1E: other  = "2";
            8'h26: other  = "3";
            8'h25: other  = "4";
            8'h2E: other  = "5";
            8'h36: other  = "6";
            8'h3D: other  = "7";
            8'h3E: other  = "8";
            8'h46: other  = "9";
            8'h29: other  = 8'h20;
            8'h5A: other  = 8'h0D;
            default: begin
                letter = 8'h00;
                other  = 8'h00;
            end
        endcase

        ascii_o = 8'h00;
        if (!ext_i) begin
            if (letter != 8'h00) begin
                ascii_o = upper_i ? (letter - 8'h20) : letter;
            end else begin
                ascii_o = other;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ============================================================================
// Module   : ps2_key_decoder
// Brief    : Folds E0/F0 prefixes into key events, tracks Shift/Ctrl/Caps and
//            counts presses. Optional PS2_TYPEMATIC_FILTER_EN drops auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         kb_data,
    input  logic               kb_ready,
    output logic               kb_nextdata_n,
    output logic               evt_valid,
    output logic [7:0]         evt_code,
    output logic               evt_ext,
    output logic               evt_break,
    output logic [7:0]         evt_ascii,
    output logic               shift,
    output logic               ctrl,
    output logic               caps,
    output logic [COUNT_W-1:0] press_count,
    output logic [1:0]         state
);

    ps2_state_t         state_q, state_d;
    logic [7:0]         byte_q;
    logic               ext_pend_q, ext_pend_d;
    logic               brk_pend_q, brk_pend_d;
    logic               caps_held_q, caps_held_d;
    logic               shift_q, shift_d;
    logic               ctrl_q, ctrl_d;
    logic               caps_q, caps_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               evt_valid_q, evt_valid_d;
    logic [7:0]         evt_code_q, evt_code_d;
    logic               evt_ext_q, evt_ext_d;
    logic               evt_break_q, evt_break_d;
    logic [7:0]         evt_ascii_q, evt_ascii_d;

    logic [7:0]         ascii_lut;
    logic               is_shift, is_ctrl, is_caps, is_mod, is_prefix;
    logic               drop_repeat;

    assign is_shift  = (byte_q == SC_LSHIFT) || (byte_q == SC_RSHIFT);
    assign is_ctrl   = (byte_q == SC_CTRL);
    assign is_caps   = (byte_q == SC_CAPS);
    assign is_mod    = is_shift || is_ctrl || is_caps;
    assign is_prefix = (byte_q == SC_EXT) || (byte_q == SC_BREAK);

    ps2_scan_to_ascii u_lut (
        .code_i  (byte_q),
        .ext_i   (ext_pend_q),
        .upper_i (shift_q ^ caps_q),
        .ascii_o (ascii_lut)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (kb_ready) state_d = ST_POP;
            ST_POP:    state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_DECODE;
            ST_DECODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The decode is registered on the SETTLE->DECODE edge so every event
    // output is already valid for the whole DECODE cycle.
    always_comb begin
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        caps_held_d = caps_held_q;
        shift_d     = shift_q;
        ctrl_d      = ctrl_q;
        caps_d      = caps_q;
        count_d     = count_q;
        evt_valid_d = 1'b0;
        evt_code_d  = evt_code_q;
        evt_ext_d   = evt_ext_q;
        evt_break_d = evt_break_q;
        evt_ascii_d = evt_ascii_q;

        if (state_q == ST_SETTLE) begin
            if (byte_q == SC_EXT) begin
                ext_pend_d = 1'b1;
            end else if (byte_q == SC_BREAK) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
                if (!drop_repeat) begin
                    evt_valid_d = 1'b1;
                    evt_code_d  = byte_q;
                    evt_ext_d   = ext_pend_q;
                    evt_break_d = brk_pend_q;
                    evt_ascii_d = ascii_lut;
                    if (is_shift) shift_d = !brk_pend_q;
                    if (is_ctrl)  ctrl_d  = !brk_pend_q;
                    if (is_caps) begin
                        caps_held_d = !brk_pend_q;
                        if (!brk_pend_q && !caps_held_q) caps_d = !caps_q;
                    end
                    if (!is_mod && !brk_pend_q) count_d = count_q + COUNT_W'(1);
                end
            end
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_valid_q, held_valid_d;
    logic [7:0] held_code_q, held_code_d;
    logic       held_ext_q, held_ext_d;
    logic       held_match;

    assign held_match  = held_valid_q && (held_code_q == byte_q) && (held_ext_q == ext_pend_q);
    assign drop_repeat = held_match && !brk_pend_q && !is_mod;

    always_comb begin
        held_valid_d = held_valid_q;
        held_code_d  = held_code_q;
        held_ext_d   = held_ext_q;
        if ((state_q == ST_SETTLE) && !is_prefix && !is_mod) begin
            if (!brk_pend_q) begin
                held_valid_d = 1'b1;
                held_code_d  = byte_q;
                held_ext_d   = ext_pend_q;
            end else if (held_match) begin
                held_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_valid_q <= 1'b0;
            held_code_q  <= 8'h00;
            held_ext_q   <= 1'b0;
        end else begin
            held_valid_q <= held_valid_d;
            held_code_q  <= held_code_d;
            held_ext_q   <= held_ext_d;
        end
    end
`else
    assign drop_repeat = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            byte_q      <= 8'h00;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            caps_held_q <= 1'b0;
            shift_q     <= 1'b0;
            ctrl_q      <= 1'b0;
            caps_q      <= 1'b0;
            count_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= 8'h00;
            evt_ext_q   <= 1'b0;
            evt_break_q <= 1'b0;
            evt_ascii_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            if (state_q == ST_POP) byte_q <= kb_data;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            caps_held_q <= caps_held_d;
            shift_q     <= shift_d;
            ctrl_q      <= ctrl_d;
            caps_q      <= caps_d;
            count_q     <= count_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            evt_ext_q   <= evt_ext_d;
            evt_break_q <= evt_break_d;
            evt_ascii_q <= evt_ascii_d;
        end
    end

    assign kb_nextdata_n = (state_q != ST_POP);
    assign evt_valid     = evt_valid_q;
    assign evt_code      = evt_code_q;
    assign evt_ext       = evt_ext_q;
    assign evt_break     = evt_break_q;
    assign evt_ascii     = evt_ascii_q;
    assign shift         = shift_q;
    assign ctrl          = ctrl_q;
    assign caps          = caps_q;
    assign press_count   = count_q;
    assign state         = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// ============================================================================
// Module   : tb_ps2_key_decoder
// Brief    : Self-checking bench: FIFO model + key-event reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_key_decoder;

    localparam int CW = 8;
    localparam logic [7:0] LETTER_SC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
        8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGIT_SC [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h36, 8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] KEY_POOL [12] = '{8'h1C, 8'h32, 8'h16, 8'h45, 8'h29, 8'h5A,
        8'h12, 8'h59, 8'h14, 8'h58, 8'h77, 8'h1A};

`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    kb_data;
    logic          kb_ready;
    logic          kb_nextdata_n, evt_valid, evt_ext, evt_break, shift, ctrl, caps;
    logic [7:0]    evt_code, evt_ascii;
    logic [CW-1:0] press_count;
    logic [1:0]    state;

    ps2_key_decoder #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_nextdata_n(kb_nextdata_n), .evt_valid(evt_valid), .evt_code(evt_code),
        .evt_ext(evt_ext), .evt_break(evt_break), .evt_ascii(evt_ascii),
        .shift(shift), .ctrl(ctrl), .caps(caps), .press_count(press_count), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]    code;
        logic          ext;
        logic          brk;
        logic [7:0]    ascii;
        logic          sh;
        logic          ct;
        logic          cp;
        logic [CW-1:0] cnt;
    } vis_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } ev_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] fifo [$];
    bit   pend_pop = 1'b0;
    ev_t  log_q [$];

    // Reference model state
    bit         m_ext, m_brk, m_shift, m_ctrl, m_caps, m_caps_held;
    logic [CW-1:0] m_cnt;
    bit         m_held_v, m_held_ext;
    logic [7:0] m_held_code;
    bit         sched_valid;
    int         sched_cyc;
    vis_t       sched_rec, vis;
    int         last_pop;
    bit         last_backlog;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ascii_of(input logic [7:0] code, input bit ext, input bit upper);
        if (ext) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (code == LETTER_SC[i]) return (upper ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (code == DIGIT_SC[i]) return 8'h30 + 8'(i);
        if (code == 8'h29) return 8'h20;
        if (code == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    function automatic void model_reset();
        m_ext = 0; m_brk = 0; m_shift = 0; m_ctrl = 0; m_caps = 0; m_caps_held = 0;
        m_cnt = '0; m_held_v = 0; m_held_ext = 0; m_held_code = 8'h00;
        sched_valid = 0; sched_cyc = 0; sched_rec = '0; vis = '0;
        last_pop = -100; last_backlog = 0;
    endfunction

    // Decides what a popped byte must produce and when it must become visible.
    function automatic void model_byte(input logic [7:0] b, input int when);
        bit is_mod, emit;
        vis_t r;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            is_mod = (b == 8'h12) || (b == 8'h59) || (b == 8'h14) || (b == 8'h58);
            emit = 1;
            r.code  = b;
            r.ext   = m_ext;
            r.brk   = m_brk;
            r.ascii = ascii_of(b, m_ext, m_shift ^ m_caps);
            if (FILTER && !is_mod) begin
                if (!m_brk) begin
                    if (m_held_v && m_held_code == b && m_held_ext == m_ext) emit = 0;
                    m_held_v = 1; m_held_code = b; m_held_ext = m_ext;
                end else if (m_held_v && m_held_code == b && m_held_ext == m_ext) begin
                    m_held_v = 0;
                end
            end
            if (emit) begin
                if (b == 8'h12 || b == 8'h59) m_shift = !m_brk;
                if (b == 8'h14) m_ctrl = !m_brk;
                if (b == 8'h58) begin
                    if (!m_brk && !m_caps_held) m_caps = !m_caps;
                    m_caps_held = !m_brk;
                end
                if (!is_mod && !m_brk) m_cnt = m_cnt + 1'b1;
                r.sh = m_shift; r.ct = m_ctrl; r.cp = m_caps; r.cnt = m_cnt;
                sched_rec = r; sched_valid = 1; sched_cyc = when;
            end
            m_ext = 0; m_brk = 0;
        end
    endfunction

    // FIFO driver: the pop takes effect on the clock edge ending the POP cycle.
    initial begin : fifo_drv
        kb_ready = 1'b0;
        kb_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (pend_pop) begin
                if (fifo.size() > 0) fifo.delete(0);
                pend_pop = 1'b0;
            end
            kb_ready = (fifo.size() != 0);
            kb_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
        end
    end

    // Single compare process: every cycle out of reset.
    initial begin : monitor
        bit exp_valid;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) continue;
            exp_valid = 1'b0;
            if (sched_valid && sched_cyc == cyc) begin
                vis = sched_rec;
                exp_valid = 1'b1;
                sched_valid = 1'b0;
            end
            check("outputs", {exp_valid, vis},
                  {evt_valid, evt_code, evt_ext, evt_break, evt_ascii, shift, ctrl, caps, press_count});
            if (evt_valid) log_q.push_back({evt_code, evt_ext, evt_break, evt_ascii});
            if (kb_nextdata_n == 1'b0) begin
                if (fifo.size() == 0) begin
                    check("pop_nonempty", 64'd0, 64'd1);
                end else begin
                    if (last_backlog) check("pop_gap_exact", 64'(cyc - last_pop), 64'd4);
                    else check("pop_gap_min", 64'(cyc - last_pop >= 4), 64'd1);
                    model_byte(fifo[0], cyc + 2);
                    last_backlog = (fifo.size() > 1);
                    last_pop = cyc;
                    pend_pop = 1'b1;
                end
            end
        end
    end

    task automatic do_reset_now();
        reset = 1'b1;
        fifo.delete();
        pend_pop = 1'b0;
        model_reset();
        log_q.delete();
        @(negedge clk);
        check("reset_values",
              {kb_nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_ascii,
               shift, ctrl, caps, press_count, state},
              {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, {CW{1'b0}}, 2'd0});
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        do_reset_now();
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (fifo.size() == 0 && !pend_pop && state == 2'd0 && !sched_valid && !kb_ready) done = 1;
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    task automatic send(input logic [7:0] b []);
        foreach (b[i]) fifo.push_back(b[i]);
        drain();
    endtask

    task automatic chk_ev(input string name, input int idx, input logic [7:0] code,
                          input logic ext, input logic brk, input logic [7:0] ascii);
        ev_t want;
        want = {code, ext, brk, ascii};
        if (idx >= log_q.size()) check({name, "_present"}, 64'd0, 64'd1);
        else check(name, 64'(log_q[idx]), 64'(want));
    endtask

    task automatic push_key(input logic [7:0] code, input bit ext, input bit brk);
        bit swap;
        swap = ($urandom_range(0, 3) == 0);
        if (brk && swap) fifo.push_back(8'hF0);
        if (ext) begin
            fifo.push_back(8'hE0);
            if ($urandom_range(0, 4) == 0) fifo.push_back(8'hE0);
        end
        if (brk && !swap) fifo.push_back(8'hF0);
        fifo.push_back(code);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        model_reset();
        #12;
        do_reset_now();

        // Press and release of 'a'
        do_reset();
        send('{8'h1C, 8'hF0, 8'h1C});
        chk_ev("a_make", 0, 8'h1C, 1'b0, 1'b0, 8'h61);
        chk_ev("a_break", 1, 8'h1C, 1'b0, 1'b1, 8'h61);
        check("a_count", 64'(press_count), 64'd1);

        // Shifted letter
        do_reset();
        send('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
        chk_ev("shift_A", 1, 8'h1C, 1'b0, 1'b0, 8'h41);
        check("shift_end", 64'(shift), 64'd0);
        check("shift_count", 64'(press_count), 64'd1);

        // Caps lock toggles on make, not while held
        do_reset();
        send('{8'h58, 8'hF0, 8'h58, 8'h1C});
        check("caps_on", 64'(caps), 64'd1);
        chk_ev("caps_A", 2, 8'h1C, 1'b0, 1'b0, 8'h41);
        send('{8'h58, 8'h58, 8'hF0, 8'h58});
        check("caps_off", 64'(caps), 64'd0);

        // Extended ctrl
        do_reset();
        send('{8'hE0, 8'h14});
        check("ctrl_on", 64'(ctrl), 64'd1);
        chk_ev("rctrl_make", 0, 8'h14, 1'b1, 1'b0, 8'h00);
        send('{8'hE0, 8'hF0, 8'h14});
        check("ctrl_off", 64'(ctrl), 64'd0);
        chk_ev("rctrl_break", 1, 8'h14, 1'b1, 1'b1, 8'h00);

        // Auto-repeat
        do_reset();
        send('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C});
        check("repeat_count", 64'(press_count), FILTER ? 64'd1 : 64'd3);
        check("repeat_events", 64'(log_q.size()), FILTER ? 64'd2 : 64'd4);

        // Reset during SETTLE after an E0 discards the prefix
        do_reset();
        send('{8'hE0});
        fifo.push_back(8'h1C);
        begin
            bit hit = 0;
            for (int i = 0; i < 20 && !hit; i++) begin
                @(posedge clk);
                #2;
                if (state == 2'd2) hit = 1;
            end
            check("reach_settle", 64'(hit), 64'd1);
        end
        do_reset_now();
        send('{8'h1C});
        chk_ev("post_reset", 0, 8'h1C, 1'b0, 1'b0, 8'h61);
        check("post_reset_count", 64'(press_count), 64'd1);

        // Counter wrap: 257 presses back-to-back
        do_reset();
        for (int i = 0; i < 257; i++) fifo.push_back((i % 2 == 0) ? 8'h1C : 8'h32);
        drain();
        check("count_wrap", 64'(press_count), 64'd1);

        // Randomized key traffic
        do_reset();
        for (int g = 0; g < 350; g++) begin
            if ($urandom_range(0, 9) == 0) begin
                fifo.push_back(8'($urandom_range(0, 255)));
            end else begin
                push_key(KEY_POOL[$urandom_range(0, 11)], $urandom_range(0, 4) == 0,
                         $urandom_range(0, 9) < 4);
            end
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
